// File: rtl/temp_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : temp_mon_pkg
// Description : Shared constants, FSM state type and width helper for the
//               temperature averaging block.
//               Optional macro TEMP_AVG_RANGE_CHECK_EN uses TEMP_MIN/TEMP_MAX.
// Revision    : 1.0 - initial release
// ============================================================================
package temp_mon_pkg;

    // Acceptable reading window when range checking is compiled in
    localparam int TEMP_MIN      = 0;
    localparam int TEMP_MAX      = 60;

    // Default configuration of the averaging block
    localparam int SENSOR_NR_DEF = 5;
    localparam int DATA_W_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } temp_avg_state_t;

    // Sum width wide enough for SENSOR_NR readings of full scale
    function automatic int calc_sum_w(input int sensor_nr, input int data_w);
        return data_w + $clog2(sensor_nr + 1);
    endfunction

endpackage : temp_mon_pkg
`default_nettype wire

// File: rtl/temp_serial_divider.sv
`default_nettype none
// ============================================================================
// Module      : temp_serial_divider
// Description : Restoring serial divider, one quotient bit per clock, MSB
//               first. DIVIDEND_W iterations after the start cycle; o_done
//               pulses for one cycle once quotient/remainder are final.
// Ports       : clk, rst (async, active-high)
//               i_start      - load operands and begin (ignored while busy)
//               i_dividend   - DIVIDEND_W-bit unsigned dividend
//               i_divisor    - DIVISOR_W-bit unsigned divisor (non-zero)
//               o_done       - one-cycle completion pulse
//               o_quotient   - quotient, held until the next start
//               o_remainder  - remainder, held until the next start
// Revision    : 1.0 - initial release
// ============================================================================
module temp_serial_divider #(
    parameter int DIVIDEND_W = 11,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [DIVISOR_W-1:0]  i_divisor,
    output logic                  o_done,
    output logic [DIVIDEND_W-1:0] o_quotient,
    output logic [DIVISOR_W-1:0]  o_remainder
);

    localparam int c_cnt_w = $clog2(DIVIDEND_W + 1);

    logic                  r_busy;
    logic                  r_done;
    logic [c_cnt_w-1:0]    r_cnt;
    // Holds the unconsumed dividend bits in the top, quotient bits shift in
    // at the bottom; after the last iteration it is the full quotient.
    logic [DIVIDEND_W-1:0] r_quot;
    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVISOR_W-1:0]  r_divisor;

    logic [DIVISOR_W:0]    w_trial;
    logic                  w_ge;
    logic [DIVISOR_W-1:0]  w_diff;
    logic [DIVISOR_W-1:0]  w_rem_next;

    assign w_trial    = {r_rem, r_quot[DIVIDEND_W-1]};
    assign w_ge       = (w_trial >= {1'b0, r_divisor});
    // The subtraction result is below the divisor, so the low bits suffice
    assign w_diff     = w_trial[DIVISOR_W-1:0] - r_divisor;
    assign w_rem_next = w_ge ? w_diff : w_trial[DIVISOR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_busy) begin
                r_quot <= {r_quot[DIVIDEND_W-2:0], w_ge};
                r_rem  <= w_rem_next;
                r_cnt  <= r_cnt - c_cnt_w'(1);
                if (r_cnt == c_cnt_w'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end else if (i_start) begin
                r_quot    <= i_dividend;
                r_rem     <= '0;
                r_divisor <= i_divisor;
                r_cnt     <= c_cnt_w'(DIVIDEND_W);
                r_busy    <= 1'b1;
            end
        end
    end

    assign o_done      = r_done;
    assign o_quotient  = r_quot;
    assign o_remainder = r_rem;

endmodule : temp_serial_divider
`default_nettype wire

// File: rtl/temp_average_calc.sv
`default_nettype none
// ============================================================================
// Module      : temp_average_calc
// Description : Averages the valid sensor readings: captures all readings on
//               start_i, accumulates one sensor per cycle, then divides the
//               sum by the active-sensor count with a serial divider. Results
//               stay stable between done_o pulses.
// Ports       : clk_i, rst_i (async, active-high)
//               start_i, sensors_data_i, sensors_valid_i - run request/inputs
//               busy_o, done_o                           - run status
//               temp_Q_o, temp_R_o, active_sensors_nr_o  - average result
//               no_sensor_o                              - zero-sensor run
//               out_of_range_o - only with TEMP_AVG_RANGE_CHECK_EN defined;
//                                a valid reading outside [TEMP_MIN,TEMP_MAX]
//                                was rejected in the last run
// Revision    : 1.0 - initial release
// ============================================================================
module temp_average_calc
    import temp_mon_pkg::*;
#(
    parameter int SENSOR_NR = SENSOR_NR_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int OUT_W     = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [SENSOR_NR*DATA_W-1:0] sensors_data_i,
    input  logic [SENSOR_NR-1:0]        sensors_valid_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [OUT_W-1:0]            temp_Q_o,
    output logic [OUT_W-1:0]            temp_R_o,
    output logic [7:0]                  active_sensors_nr_o,
    output logic                        no_sensor_o
`ifdef TEMP_AVG_RANGE_CHECK_EN
    ,
    output logic                        out_of_range_o
`endif
);

    localparam int c_sum_w = calc_sum_w(SENSOR_NR, DATA_W);
    localparam int c_idx_w = (SENSOR_NR > 1) ? $clog2(SENSOR_NR) : 1;

    temp_avg_state_t r_state;
    temp_avg_state_t w_state_next;

    // Captured readings shift down one sensor per ACC cycle, so the current
    // sensor always sits in the low slice.
    logic [SENSOR_NR*DATA_W-1:0] r_data;
    logic [SENSOR_NR-1:0]        r_valid;
    logic [c_sum_w-1:0]          r_sum;
    logic [7:0]                  r_count;
    logic [c_idx_w-1:0]          r_idx;

    logic [OUT_W-1:0]            r_q;
    logic [OUT_W-1:0]            r_r;
    logic [7:0]                  r_nr;
    logic                        r_no_sensor;

    logic [DATA_W-1:0]           w_cur;
    logic                        w_use;
    logic                        w_last;
    logic [c_sum_w-1:0]          w_sum_next;
    logic [7:0]                  w_count_next;
    logic                        w_div_start;
    logic                        w_div_done;
    logic [c_sum_w-1:0]          w_quot;
    logic [7:0]                  w_rem;

    assign w_cur  = r_data[DATA_W-1:0];
    assign w_last = (r_idx == c_idx_w'(SENSOR_NR - 1));

`ifdef TEMP_AVG_RANGE_CHECK_EN
    logic r_oor_run;
    logic r_oor;
    logic w_in_range;
    logic w_reject;

    assign w_in_range     = (int'(w_cur) >= TEMP_MIN) && (int'(w_cur) <= TEMP_MAX);
    assign w_reject       = r_valid[0] && !w_in_range;
    assign w_use          = r_valid[0] && w_in_range;
    assign out_of_range_o = r_oor;
`else
    assign w_use = r_valid[0];
`endif

    assign w_sum_next   = r_sum + (w_use ? c_sum_w'(w_cur) : c_sum_w'(0));
    assign w_count_next = r_count + (w_use ? 8'd1 : 8'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy_o       = 1'b1;
        done_o       = 1'b0;
        w_div_start  = 1'b0;
        case (r_state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    w_state_next = ACC;
                end
            end
            ACC: begin
                if (w_last) begin
                    if (w_count_next != 8'd0) begin
                        // Divider is fed the final sum/count combinationally
                        // so it loads on the same edge DIV is entered.
                        w_div_start  = 1'b1;
                        w_state_next = DIV;
                    end else begin
                        w_state_next = DONE;
                    end
                end
            end
            DIV: begin
                if (w_div_done) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done_o       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data      <= '0;
            r_valid     <= '0;
            r_sum       <= '0;
            r_count     <= '0;
            r_idx       <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_nr        <= '0;
            r_no_sensor <= 1'b0;
`ifdef TEMP_AVG_RANGE_CHECK_EN
            r_oor_run   <= 1'b0;
            r_oor       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_data    <= sensors_data_i;
                        r_valid   <= sensors_valid_i;
                        r_sum     <= '0;
                        r_count   <= '0;
                        r_idx     <= '0;
`ifdef TEMP_AVG_RANGE_CHECK_EN
                        r_oor_run <= 1'b0;
`endif
                    end
                end
                ACC: begin
                    r_sum   <= w_sum_next;
                    r_count <= w_count_next;
                    r_idx   <= r_idx + c_idx_w'(1);
                    r_data  <= r_data >> DATA_W;
                    r_valid <= r_valid >> 1;
`ifdef TEMP_AVG_RANGE_CHECK_EN
                    r_oor_run <= r_oor_run | w_reject;
`endif
                    if (w_last && (w_count_next == 8'd0)) begin
                        r_q         <= '0;
                        r_r         <= '0;
                        r_nr        <= '0;
                        r_no_sensor <= 1'b1;
`ifdef TEMP_AVG_RANGE_CHECK_EN
                        r_oor       <= r_oor_run | w_reject;
`endif
                    end
                end
                DIV: begin
                    if (w_div_done) begin
                        r_q         <= OUT_W'(w_quot);
                        r_r         <= OUT_W'(w_rem);
                        r_nr        <= r_count;
                        r_no_sensor <= 1'b0;
`ifdef TEMP_AVG_RANGE_CHECK_EN
                        r_oor       <= r_oor_run;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    temp_serial_divider #(
        .DIVIDEND_W (c_sum_w),
        .DIVISOR_W  (8)
    ) u_divider (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_start     (w_div_start),
        .i_dividend  (w_sum_next),
        .i_divisor   (w_count_next),
        .o_done      (w_div_done),
        .o_quotient  (w_quot),
        .o_remainder (w_rem)
    );

    assign temp_Q_o            = r_q;
    assign temp_R_o            = r_r;
    assign active_sensors_nr_o = r_nr;
    assign no_sensor_o         = r_no_sensor;

endmodule : temp_average_calc
`default_nettype wire

// File: tb/tb_temp_average_calc.sv
`default_nettype none
// ============================================================================
// Module      : tb_temp_average_calc
// Description : Self-checking bench for temp_average_calc: behavioural
//               average model compared every cycle, directed literal runs,
//               randomized runs, held start, mid-run reset.
//               Honours TEMP_AVG_RANGE_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_temp_average_calc;

    localparam int SENSOR_NR = 5;
    localparam int DATA_W    = 8;
    localparam int OUT_W     = 16;
    localparam int DW        = SENSOR_NR * DATA_W;
    localparam int SUM_W     = DATA_W + $clog2(SENSOR_NR + 1);
    localparam int LAT       = SENSOR_NR + SUM_W + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [DW-1:0]        data;
    logic [SENSOR_NR-1:0] mask;
    logic                 busy;
    logic                 done;
    logic [OUT_W-1:0]     q;
    logic [OUT_W-1:0]     r;
    logic [7:0]           nr;
    logic                 nos;
`ifdef TEMP_AVG_RANGE_CHECK_EN
    logic                 oor;
`endif

    temp_average_calc #(
        .SENSOR_NR (SENSOR_NR),
        .DATA_W    (DATA_W),
        .OUT_W     (OUT_W)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .start_i             (start),
        .sensors_data_i      (data),
        .sensors_valid_i     (mask),
        .busy_o              (busy),
        .done_o              (done),
        .temp_Q_o            (q),
        .temp_R_o            (r),
        .active_sensors_nr_o (nr),
        .no_sensor_o         (nos)
`ifdef TEMP_AVG_RANGE_CHECK_EN
        ,
        .out_of_range_o      (oor)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Average as defined by the rules: plain sum/count over accepted readings
    function automatic void ref_calc(input logic [DW-1:0] d, input logic [SENSOR_NR-1:0] m,
                                     output int eq, output int er, output int enr, output bit eoor);
        int sum;
        int v;
        sum  = 0;
        enr  = 0;
        eoor = 0;
        for (int k = 0; k < SENSOR_NR; k++) begin
            v = int'(d[k*DATA_W +: DATA_W]);
            if (m[k]) begin
`ifdef TEMP_AVG_RANGE_CHECK_EN
                if (v > 60) begin
                    eoor = 1;
                    continue;
                end
`endif
                sum += v;
                enr++;
            end
        end
        if (enr == 0) begin
            eq = 0;
            er = 0;
        end else begin
            eq = sum / enr;
            er = sum % enr;
        end
    endfunction

    // Model: a run lasts LAT edges (SENSOR_NR when nothing is counted),
    // then a single DONE cycle during which start is ignored.
    int m_left = 0;
    bit m_done = 0;
    int m_q = 0, m_r = 0, m_nr = 0;
    bit m_nos = 0, m_oor = 0;
    int p_q, p_r, p_nr;
    bit p_oor;
    int m_done_cnt = 0;
    int dut_done_cnt = 0;
    bit mon_en = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_done = 0;
            m_q = 0; m_r = 0; m_nr = 0; m_nos = 0; m_oor = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1;
                m_q    = p_q;
                m_r    = p_r;
                m_nr   = p_nr;
                m_nos  = (p_nr == 0);
                m_oor  = p_oor;
                m_done_cnt++;
            end
        end else if (start) begin
            ref_calc(data, mask, p_q, p_r, p_nr, p_oor);
            m_left = (p_nr != 0) ? LAT : SENSOR_NR;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (done === 1'b1) dut_done_cnt++;
            chk("busy",  32'(busy), 32'((m_left > 0) || m_done));
            chk("done",  32'(done), 32'(m_done));
            chk("q",     32'(q),    m_q);
            chk("r",     32'(r),    m_r);
            chk("nr",    32'(nr),   m_nr);
            chk("nos",   32'(nos),  32'(m_nos));
`ifdef TEMP_AVG_RANGE_CHECK_EN
            chk("oor",   32'(oor),  32'(m_oor));
`endif
            if (nr != 8'd0) chk("r_lt_nr", 32'(r < OUT_W'(nr)), 32'd1);
            chk("q_le_max", 32'(q <= OUT_W'(255)), 32'd1);
        end
    end

    function automatic logic [DW-1:0] pack(input int a, input int b, input int c, input int d, input int e);
        return {8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Start is pulsed for one cycle; inputs are scrambled right after acceptance
    task automatic launch(input logic [DW-1:0] d, input logic [SENSOR_NR-1:0] m);
        @(posedge clk);
        #1;
        data  = d;
        mask  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        data  = DW'({$urandom, $urandom});
        mask  = SENSOR_NR'($urandom);
    endtask

    task automatic wait_done(output int cyc, output bit ok);
        ok  = 0;
        cyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok  = 1;
                cyc = i;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no done_o, expected one within 40 cycles (t=%0t)", $time);
        end
    endtask

    task automatic directed(input string name, input logic [DW-1:0] d, input logic [SENSOR_NR-1:0] m,
                            input int eq, input int er, input int enr, input int enos);
        int cyc;
        bit ok;
        launch(d, m);
        wait_done(cyc, ok);
        if (ok) begin
            if (enr != 0) chk({name, "_latency"}, cyc, LAT);
            chk({name, "_q"},   32'(q),   eq);
            chk({name, "_r"},   32'(r),   er);
            chk({name, "_nr"},  32'(nr),  enr);
            chk({name, "_nos"}, 32'(nos), enos);
        end
    endtask

    initial begin
        int cyc;
        bit ok;
        int base;
        logic [DW-1:0] d;
        int v;

        rst   = 1'b1;
        start = 1'b0;
        data  = '0;
        mask  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_q",    32'(q),    0);
        chk("rst_r",    32'(r),    0);
        chk("rst_nr",   32'(nr),   0);
        chk("rst_nos",  32'(nos),  0);
        rst    = 1'b0;
        mon_en = 1'b1;

        directed("all5",   pack(20, 21, 22, 23, 24), 5'b11111, 22, 0, 5, 0);
        directed("two",    pack(20, 25, 99, 7, 3),   5'b00011, 22, 1, 2, 0);
        directed("three",  pack(20, 21, 23, 90, 5),  5'b00111, 21, 1, 3, 0);
        directed("none",   pack(20, 21, 23, 90, 5),  5'b00000, 0, 0, 0, 1);
        directed("one",    pack(19, 200, 1, 2, 3),   5'b00001, 19, 0, 1, 0);
`ifdef TEMP_AVG_RANGE_CHECK_EN
        directed("full",   pack(255, 255, 255, 255, 255), 5'b11111, 0, 0, 0, 1);
        chk("full_oor", 32'(oor), 1);
        directed("range",  pack(20, 70, 22, 23, 24), 5'b11111, 22, 1, 4, 0);
        chk("range_oor", 32'(oor), 1);
`else
        directed("full",   pack(255, 255, 255, 255, 255), 5'b11111, 255, 0, 5, 0);
`endif

        // Start held high for 30 cycles with inputs changing every cycle
        @(posedge clk);
        #1;
        start = 1'b1;
        data  = DW'({$urandom, $urandom});
        mask  = SENSOR_NR'($urandom);
        base  = dut_done_cnt;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            data = DW'({$urandom, $urandom});
            mask = SENSOR_NR'($urandom);
        end
        chk("held_done_pulses", dut_done_cnt - base, 1);
        start = 1'b0;
        wait_done(cyc, ok);

        // Reset in the middle of a run
        launch(pack(10, 20, 30, 40, 50), 5'b11111);
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_q",    32'(q),    0);
        chk("midrst_nr",   32'(nr),   0);
        chk("midrst_nos",  32'(nos),  0);
        @(posedge clk);
        #2;
        rst  = 1'b0;
        base = dut_done_cnt;
        repeat (25) @(negedge clk);
        chk("midrst_no_done", dut_done_cnt - base, 0);
        directed("after_rst", pack(30, 0, 40, 0, 50), 5'b10101, 40, 0, 3, 0);

        // Randomized runs, checked each cycle by the model
        for (int t = 0; t < 40; t++) begin
            d = '0;
            for (int k = 0; k < SENSOR_NR; k++) begin
                v = (t % 2 == 1) ? int'($urandom_range(0, 80)) : int'($urandom_range(0, 255));
                d[k*DATA_W +: DATA_W] = DATA_W'(v);
            end
            launch(d, SENSOR_NR'($urandom));
            wait_done(cyc, ok);
        end

        repeat (3) @(negedge clk);
        chk("done_count", dut_done_cnt, m_done_cnt);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_temp_average_calc
`default_nettype wire
